// File: rtl/tree_dispatch_node.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tree_dispatch_node: forwards one parent command to its children by         |
// | broadcast or round-robin unicast, and returns one done/error response.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tree_dispatch_node #(
  parameter int NUM_CHILDREN = 10,
  parameter int DATA_W       = 32,
  parameter int TIMEOUT_CYC  = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    up_valid,
  output logic                    up_ready,
  input  logic [DATA_W-1:0]       up_data,
  input  logic                    up_bcast,
  output logic                    up_done,
  output logic                    up_err,
  output logic [NUM_CHILDREN-1:0] up_done_mask,
  output logic [NUM_CHILDREN-1:0] dn_valid,
  input  logic [NUM_CHILDREN-1:0] dn_ready,
  output logic [DATA_W-1:0]       dn_data,
  input  logic [NUM_CHILDREN-1:0] dn_done,
  output logic [((NUM_CHILDREN > 1) ? $clog2(NUM_CHILDREN) : 1)-1:0] rr_ptr,
  output logic                    busy
);

  localparam int c_RR_W = (NUM_CHILDREN > 1) ? $clog2(NUM_CHILDREN) : 1;
  localparam int c_TC_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [c_RR_W-1:0]       c_RR_LAST = c_RR_W'(NUM_CHILDREN - 1);
  localparam logic [c_TC_W-1:0]       c_TC_LAST = c_TC_W'(TIMEOUT_CYC - 1);
  localparam logic [NUM_CHILDREN-1:0] c_ONE     = NUM_CHILDREN'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t                  r_state;
  logic [DATA_W-1:0]       r_data;
  logic [NUM_CHILDREN-1:0] r_target;
  logic [NUM_CHILDREN-1:0] r_pend;
  logic [NUM_CHILDREN-1:0] r_donem;
  logic [NUM_CHILDREN-1:0] r_done_mask;
  logic [c_TC_W-1:0]       r_tcnt;
  logic [c_RR_W-1:0]       r_rr;
  logic                    r_bcast;
  logic                    r_up_ready;
  logic                    r_up_done;
  logic                    r_up_err;
  logic                    r_busy;

  logic [NUM_CHILDREN-1:0] w_acc;
  logic [NUM_CHILDREN-1:0] w_donem_nxt;
  logic [NUM_CHILDREN-1:0] w_onehot;
  logic [c_RR_W-1:0]       w_rr_nxt;
  logic                    w_all_done;
  logic                    w_tmo_hit;

  // A done only counts from a targeted child that has accepted, now or earlier.
  assign w_acc       = r_pend & dn_ready;
  assign w_donem_nxt = r_donem | (dn_done & r_target & ((r_target & ~r_pend) | w_acc));
  assign w_all_done  = (w_donem_nxt == r_target);
  assign w_tmo_hit   = (TIMEOUT_CYC != 0) && (r_tcnt == c_TC_LAST);
  assign w_onehot    = c_ONE << r_rr;
  assign w_rr_nxt    = (r_rr == c_RR_LAST) ? '0 : r_rr + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_data      <= '0;
      r_target    <= '0;
      r_pend      <= '0;
      r_donem     <= '0;
      r_done_mask <= '0;
      r_tcnt      <= '0;
      r_rr        <= '0;
      r_bcast     <= 1'b0;
      r_up_ready  <= 1'b1;
      r_up_done   <= 1'b0;
      r_up_err    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (up_valid) begin
            r_data     <= up_data;
            r_target   <= up_bcast ? '1 : w_onehot;
            r_pend     <= up_bcast ? '1 : w_onehot;
            r_donem    <= '0;
            r_tcnt     <= '0;
            r_bcast    <= up_bcast;
            r_up_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_pend  <= r_pend & ~dn_ready;
          r_donem <= w_donem_nxt;
          if (r_tcnt != '1) begin
            r_tcnt <= r_tcnt + 1'b1;
          end
          // Completion takes priority over a coincident timeout.
          if (w_all_done || w_tmo_hit) begin
            r_pend      <= '0;
            r_up_done   <= 1'b1;
            r_up_err    <= !w_all_done;
            r_done_mask <= w_donem_nxt;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (!r_bcast) begin
            r_rr <= w_rr_nxt;
          end
          r_up_done   <= 1'b0;
          r_up_err    <= 1'b0;
          r_done_mask <= '0;
          r_up_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign up_ready     = r_up_ready;
  assign up_done      = r_up_done;
  assign up_err       = r_up_err;
  assign up_done_mask = r_done_mask;
  assign dn_valid     = r_pend;
  assign dn_data      = r_data;
  assign rr_ptr       = r_rr;
  assign busy         = r_busy;

endmodule
`default_nettype wire

// File: doc/tree_dispatch_node.md
Name: tree_dispatch_node

Overview:
Parametrised hierarchy node that takes one command from its parent and dispatches it to NUM_CHILDREN child instances. In broadcast mode the command goes to all children; in unicast mode it goes to one child, selected round-robin. The node collects per-child completion, then returns a single done/error response upstream. Nodes chain level by level to form arbitrarily deep and wide dispatch trees.

Parameters:
NUM_CHILDREN, 10, number of child ports (>=1)
DATA_W, 32, command payload width
TIMEOUT_CYC, 255, cycles from entering ISSUE before abort; 0 disables timeout

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
up_valid  in  1  parent command valid
up_ready  out  1  node can accept command
up_data  in  DATA_W  command payload
up_bcast  in  1  1 = broadcast to all children, 0 = unicast round-robin
up_done  out  1  one-cycle completion pulse
up_err  out  1  valid with up_done; 1 = timeout abort
up_done_mask  out  NUM_CHILDREN  children that completed; valid with up_done
dn_valid  out  NUM_CHILDREN  per-child command valid
dn_ready  in  NUM_CHILDREN  per-child accept
dn_data  out  DATA_W  captured payload, shared by all children
dn_done  in  NUM_CHILDREN  per-child completion pulse
rr_ptr  out  $clog2(NUM_CHILDREN) (min 1)  next unicast target
busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr_ptr=0, all masks and the timeout counter = 0. Reset values: up_ready=1, dn_valid=0, up_done=0, up_err=0, up_done_mask=0, dn_data=0, busy=0.
- States: IDLE, ISSUE, RESP.
- IDLE: up_ready=1. On up_valid&up_ready:
  - capture up_data into dn_data;
  - target = all-ones if up_bcast, else one-hot(rr_ptr);
  - pend = target; donem = 0; tcnt = 0; go to ISSUE.
- ISSUE: up_ready=0; dn_valid = pend.
  - Each cycle, pend &= ~(dn_valid & dn_ready).
  - dn_valid[i] stays high until child i accepts. Data is held stable throughout.
  - donem |= dn_done & target & (accepted_before | accepting_now). A done from a child that has not accepted, or is not in target, is ignored.
  - When next donem == target, go to RESP.
  - Otherwise, if TIMEOUT_CYC != 0 and tcnt == TIMEOUT_CYC-1, go to RESP with timeout flagged.
  - tcnt increments each cycle in ISSUE and saturates.
- RESP (exactly 1 cycle):
  - up_done=1; up_done_mask=donem; up_err=1 iff exit was by timeout; dn_valid=0.
  - If the command was unicast, rr_ptr advances, wrapping NUM_CHILDREN-1 -> 0.
  - Next state is IDLE.
- up_err and up_done_mask are 0 outside RESP.
- Completion and timeout in the same cycle: completion wins, up_err=0.
- Minimum latency: accept at T0; T1 dn_valid with handshake and done; T2 up_done; T3 up_ready=1. There is no back-to-back accept during RESP.
- NUM_CHILDREN=1: rr_ptr is constant 0; broadcast and unicast behave identically.
- Reset mid-operation: everything returns to reset values immediately. Commands in flight are dropped with no up_done.
- rr_ptr is unaffected by broadcast commands and by the timeout outcome (a timed-out unicast still advances).

Test Plan:
1. Broadcast, N=10, all dn_ready=1, each child pulses dn_done 3 cycles after accept. Required: dn_valid=0x3FF for 1 cycle, then up_done with up_done_mask=0x3FF and up_err=0.
2. Ten unicast commands, data 0..9, immediate ready and done. Required: targets go one-hot 0,1,...,9, then wrap to 0; rr_ptr reads 0 after the 10th command; payload on dn_data matches each command.
3. Broadcast with child 4 holding dn_ready=0 for 5 cycles. Required: dn_valid[4] stays high and dn_data stays stable; child 4's early dn_done pulse is ignored; response only after child 4 accepts and completes.
4. TIMEOUT_CYC=8, unicast to child 2, which never completes. Required: up_done 8 cycles after ISSUE entry, up_err=1, up_done_mask=0, rr_ptr=3.
5. Completion on the exact timeout cycle. Required: up_err=0, up_done_mask = target.
6. Assert rst_n=0 during ISSUE of a broadcast. Required: outputs go to reset values asynchronously, no up_done is produced, rr_ptr=0, and up_ready=1 after release.
